id_exe_stage: RTL and testbench
===============================

Name: id_exe_stage

Overview:
ID→EXE pipeline register of the 5-stage MIPS core. It consumes `_stall_en` and `bubble` from the load-use hazard detector, plus `flush` from branch resolution and `hold` from the data-memory interface. It either latches the decoded instruction, inserts a NOP bubble, or freezes. It feeds back `exe_wb_dreg`, `exe_wb_we` and `exe_mem_mem_reg` to the hazard detector.

Parameters:
- DW, 32, datapath width
- RW, 5, register index width
- AOPW, 4, ALU opcode width

Ports:
- clk  in  1  rising-edge clock
- _rst  in  1  asynchronous active-low reset
- _stall_en  in  1  0 = load-use stall in progress (ID held upstream)
- bubble  in  1  1 = insert NOP into EXE this edge
- flush  in  1  1 = branch/jump taken; kill instruction in ID
- hold  in  1  1 = memory busy; freeze entire register
- id_valid  in  1  ID slot holds a real instruction
- id_pc  in  DW  PC of ID instruction
- id_rega, id_regb  in  RW  source register indices
- id_a, id_b  in  DW  register-file read data
- id_imm  in  DW  sign/zero-extended immediate
- id_dreg  in  RW  destination register
- id_we  in  1  register write enable
- id_mem_reg  in  1  0 = result comes from memory (load); 1 = ALU
- id_mem_we  in  1  store enable
- id_aluop  in  AOPW  ALU operation
- exe_valid  out  1  EXE slot valid
- exe_pc, exe_a, exe_b, exe_imm  out  DW  registered copies
- exe_rega, exe_regb, exe_wb_dreg  out  RW  registered indices
- exe_wb_we, exe_mem_reg, exe_mem_we  out  1  registered controls
- exe_aluop  out  AOPW  registered ALU op
- bubble_seen  out  1  pulses 1 cycle after each inserted bubble

Behaviour:
- Reset (`_rst`=0, async): all outputs 0, except `exe_mem_reg`=1. This is the NOP encoding: not a load, so no false stall.
- Per-edge priority: hold > flush > bubble > load.
- hold=1: every register keeps its value; `bubble_seen` ← 0. `flush` and `bubble` are ignored that cycle.
  - Upstream re-asserts them, since the hazard inputs are combinational from the frozen state.
- flush=1, or bubble=1 with `_stall_en`=0: load NOP.
  - NOP: `exe_valid`=0, `exe_wb_we`=0, `exe_mem_we`=0, `exe_mem_reg`=1, `exe_wb_dreg`=0, `exe_aluop`=0.
  - Datapath fields (pc, a, b, imm, rega, regb) are don't-care; they are loaded with ID values to save muxes.
  - `bubble_seen` ← bubble & ~flush.
- bubble=1 with `_stall_en`=1 (illegal pairing): treat as load. Flag via assertion.
- Otherwise (load): all fields ← ID values.
  - `exe_valid` ← `id_valid`.
  - If `id_valid`=0, control bits are forced to NOP values.
- `id_dreg`=0 with `id_we`=1: passed through unchanged; r0 suppression is downstream.
- Bubble latency: the EXE slot holds the NOP exactly one cycle after the bubble edge. The load in EXE advances to MEM, so the hazard clears and ID re-issues on the next edge.
- Back-to-back bubbles: each cycle is independent; no internal state beyond registers.
- Reset mid-stall: the pipeline returns to the NOP state; `_stall_en`/`bubble` recompute as inactive.

Optional Feature:
`ID_EXE_PERF_EN`
- Defined: adds 32-bit saturating counters `perf_bubbles`, `perf_flushes` and `perf_holds`, each incremented on edges where that path is taken per the priority above.
  - Adds input `perf_clr` (synchronous, highest priority below reset) and three outputs `perf_*`.
  - Counters reset to 0 on `_rst`; they saturate at 32'hFFFF_FFFF.
- Undefined: the ports and logic are absent.

Decomposition:
- Shared package `pipe_pkg`:
  - NOP control constants: NOP_WE=0, NOP_MEM_REG=1, NOP_MEM_WE=0, NOP_ALUOP=0.
  - ALU opcode localparams.
  - Width constants DW and RW.
- One natural sub-module: `perf_counter_sat` (32-bit saturating counter with clear and inc), instantiated ×3 under the macro.

Test Plan:
1. Reset: hold `_rst`=0 with random ID inputs → `exe_valid`=0, `exe_wb_we`=0, `exe_mem_reg`=1, `exe_wb_dreg`=0. Release; next edge loads ID: `id_pc`=32'h40, `id_dreg`=5 → `exe_pc`=32'h40, `exe_wb_dreg`=5.
2. Load-use: cycle N load with `id_dreg`=8, `id_mem_reg`=0. Cycle N+1 `bubble`=1, `_stall_en`=0 → EXE is NOP at N+2, `bubble_seen`=1 at N+2. Cycle N+2 re-issued instruction latched at N+3.
3. Flush and bubble together: `flush`=1, `bubble`=1 → NOP loaded, `bubble_seen`=0.
4. Hold over bubble: `hold`=1, `bubble`=1 for 3 cycles with EXE holding `dreg`=9 → outputs unchanged across all 3 edges. Hold drops with bubble=1 → NOP on next edge.
5. Invalid ID: `id_valid`=0, `id_we`=1, `id_mem_we`=1 → `exe_wb_we`=0, `exe_mem_we`=0, `exe_valid`=0.
6. PERF (macro on): 4 bubbles, 2 flushes, 3 holds → counters 4/2/3. `perf_clr`=1 → all 0 next edge. Forced count 32'hFFFF_FFFF plus one bubble → stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: NOP control encoding, ALU opcodes, widths.
// Imported by the ID/EXE register and its helpers.
package pipe_pkg;

    localparam int DW = 32;
    localparam int RW = 5;

    localparam logic       NOP_WE      = 1'b0;
    localparam logic       NOP_MEM_REG = 1'b1;
    localparam logic       NOP_MEM_WE  = 1'b0;
    localparam logic [3:0] NOP_ALUOP   = 4'd0;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;
    localparam logic [3:0] ALU_LUI = 4'd10;

endpackage

// File: rtl/perf_counter_sat.sv
// 32-bit saturating event counter with synchronous clear.
// Clear wins over increment; the count sticks at all-ones.
module perf_counter_sat (
    input  logic        clk,
    input  logic        _rst,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [31:0] count_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != 32'hFFFF_FFFF))
            cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/id_exe_stage.sv
// ID->EXE pipeline register: hold > flush > bubble > load.
// Optional perf counters with `define ID_EXE_PERF_EN.
module id_exe_stage #(
    parameter int DW   = 32,
    parameter int RW   = 5,
    parameter int AOPW = 4
) (
    input  logic            clk,
    input  logic            _rst,
`ifdef ID_EXE_PERF_EN
    input  logic            perf_clr,
    output logic [31:0]     perf_bubbles,
    output logic [31:0]     perf_flushes,
    output logic [31:0]     perf_holds,
`endif
    input  logic            _stall_en,
    input  logic            bubble,
    input  logic            flush,
    input  logic            hold,
    input  logic            id_valid,
    input  logic [DW-1:0]   id_pc,
    input  logic [RW-1:0]   id_rega,
    input  logic [RW-1:0]   id_regb,
    input  logic [DW-1:0]   id_a,
    input  logic [DW-1:0]   id_b,
    input  logic [DW-1:0]   id_imm,
    input  logic [RW-1:0]   id_dreg,
    input  logic            id_we,
    input  logic            id_mem_reg,
    input  logic            id_mem_we,
    input  logic [AOPW-1:0] id_aluop,
    output logic            exe_valid,
    output logic [DW-1:0]   exe_pc,
    output logic [DW-1:0]   exe_a,
    output logic [DW-1:0]   exe_b,
    output logic [DW-1:0]   exe_imm,
    output logic [RW-1:0]   exe_rega,
    output logic [RW-1:0]   exe_regb,
    output logic [RW-1:0]   exe_wb_dreg,
    output logic            exe_wb_we,
    output logic            exe_mem_reg,
    output logic            exe_mem_we,
    output logic [AOPW-1:0] exe_aluop,
    output logic            bubble_seen
);

    import pipe_pkg::*;

    logic            nop_load;
    logic            ctl_live;

    logic            valid_q,   valid_d;
    logic [DW-1:0]   pc_q,      pc_d;
    logic [DW-1:0]   a_q,       a_d;
    logic [DW-1:0]   b_q,       b_d;
    logic [DW-1:0]   imm_q,     imm_d;
    logic [RW-1:0]   rega_q,    rega_d;
    logic [RW-1:0]   regb_q,    regb_d;
    logic [RW-1:0]   dreg_q,    dreg_d;
    logic            we_q,      we_d;
    logic            mem_reg_q, mem_reg_d;
    logic            mem_we_q,  mem_we_d;
    logic [AOPW-1:0] aluop_q,   aluop_d;
    logic            bseen_q,   bseen_d;

    assign nop_load = flush | (bubble & ~_stall_en);
    assign ctl_live = ~nop_load & id_valid;

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        rega_d    = rega_q;
        regb_d    = regb_q;
        dreg_d    = dreg_q;
        we_d      = we_q;
        mem_reg_d = mem_reg_q;
        mem_we_d  = mem_we_q;
        aluop_d   = aluop_q;
        bseen_d   = 1'b0;
        if (!hold) begin
            // Datapath always tracks ID; only control is squashed.
            pc_d      = id_pc;
            a_d       = id_a;
            b_d       = id_b;
            imm_d     = id_imm;
            rega_d    = id_rega;
            regb_d    = id_regb;
            valid_d   = ctl_live;
            dreg_d    = ctl_live ? id_dreg    : '0;
            we_d      = ctl_live ? id_we      : NOP_WE;
            mem_reg_d = ctl_live ? id_mem_reg : NOP_MEM_REG;
            mem_we_d  = ctl_live ? id_mem_we  : NOP_MEM_WE;
            aluop_d   = ctl_live ? id_aluop   : AOPW'(NOP_ALUOP);
            bseen_d   = nop_load & bubble & ~flush;
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            rega_q    <= '0;
            regb_q    <= '0;
            dreg_q    <= '0;
            we_q      <= NOP_WE;
            mem_reg_q <= NOP_MEM_REG;
            mem_we_q  <= NOP_MEM_WE;
            aluop_q   <= AOPW'(NOP_ALUOP);
            bseen_q   <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            rega_q    <= rega_d;
            regb_q    <= regb_d;
            dreg_q    <= dreg_d;
            we_q      <= we_d;
            mem_reg_q <= mem_reg_d;
            mem_we_q  <= mem_we_d;
            aluop_q   <= aluop_d;
            bseen_q   <= bseen_d;
        end
    end

    assign exe_valid   = valid_q;
    assign exe_pc      = pc_q;
    assign exe_a       = a_q;
    assign exe_b       = b_q;
    assign exe_imm     = imm_q;
    assign exe_rega    = rega_q;
    assign exe_regb    = regb_q;
    assign exe_wb_dreg = dreg_q;
    assign exe_wb_we   = we_q;
    assign exe_mem_reg = mem_reg_q;
    assign exe_mem_we  = mem_we_q;
    assign exe_aluop   = aluop_q;
    assign bubble_seen = bseen_q;

    // A bubble while ID is not stalled means the hazard unit is confused.
    a_bubble_pair: assert property (
        @(posedge clk) disable iff (!_rst) !(bubble && _stall_en)
    );

`ifdef ID_EXE_PERF_EN
    logic inc_bub;
    logic inc_fl;

    assign inc_bub = ~hold & ~flush & bubble & ~_stall_en;
    assign inc_fl  = ~hold & flush;

    perf_counter_sat u_cnt_bub (
        .clk     (clk),
        ._rst    (_rst),
        .clr_i   (perf_clr),
        .inc_i   (inc_bub),
        .count_o (perf_bubbles)
    );

    perf_counter_sat u_cnt_fl (
        .clk     (clk),
        ._rst    (_rst),
        .clr_i   (perf_clr),
        .inc_i   (inc_fl),
        .count_o (perf_flushes)
    );

    perf_counter_sat u_cnt_hold (
        .clk     (clk),
        ._rst    (_rst),
        .clr_i   (perf_clr),
        .inc_i   (hold),
        .count_o (perf_holds)
    );
`endif

endmodule

// File: tb/tb_id_exe_stage.sv
// Bench for id_exe_stage: rule-level model checked every cycle,
// plus directed literal expectations for each scenario.
module tb_id_exe_stage;

    logic        clk = 1'b0;
    logic        _rst = 1'b0;
    logic        _stall_en = 1'b1;
    logic        bubble = 1'b0;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc = '0;
    logic [4:0]  id_rega = '0;
    logic [4:0]  id_regb = '0;
    logic [31:0] id_a = '0;
    logic [31:0] id_b = '0;
    logic [31:0] id_imm = '0;
    logic [4:0]  id_dreg = '0;
    logic        id_we = 1'b0;
    logic        id_mem_reg = 1'b1;
    logic        id_mem_we = 1'b0;
    logic [3:0]  id_aluop = '0;

    logic        exe_valid;
    logic [31:0] exe_pc, exe_a, exe_b, exe_imm;
    logic [4:0]  exe_rega, exe_regb, exe_wb_dreg;
    logic        exe_wb_we, exe_mem_reg, exe_mem_we;
    logic [3:0]  exe_aluop;
    logic        bubble_seen;

`ifdef ID_EXE_PERF_EN
    logic        perf_clr = 1'b0;
    logic [31:0] perf_bubbles, perf_flushes, perf_holds;
`endif

    id_exe_stage dut (
        .clk         (clk),
        ._rst        (_rst),
`ifdef ID_EXE_PERF_EN
        .perf_clr    (perf_clr),
        .perf_bubbles(perf_bubbles),
        .perf_flushes(perf_flushes),
        .perf_holds  (perf_holds),
`endif
        ._stall_en   (_stall_en),
        .bubble      (bubble),
        .flush       (flush),
        .hold        (hold),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_rega     (id_rega),
        .id_regb     (id_regb),
        .id_a        (id_a),
        .id_b        (id_b),
        .id_imm      (id_imm),
        .id_dreg     (id_dreg),
        .id_we       (id_we),
        .id_mem_reg  (id_mem_reg),
        .id_mem_we   (id_mem_we),
        .id_aluop    (id_aluop),
        .exe_valid   (exe_valid),
        .exe_pc      (exe_pc),
        .exe_a       (exe_a),
        .exe_b       (exe_b),
        .exe_imm     (exe_imm),
        .exe_rega    (exe_rega),
        .exe_regb    (exe_regb),
        .exe_wb_dreg (exe_wb_dreg),
        .exe_wb_we   (exe_wb_we),
        .exe_mem_reg (exe_mem_reg),
        .exe_mem_we  (exe_mem_we),
        .exe_aluop   (exe_aluop),
        .bubble_seen (bubble_seen)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what EXE must hold, derived from the priority rules.
    bit          m_valid, m_we, m_mr, m_mw, m_bs;
    logic [31:0] m_pc, m_a, m_b, m_imm;
    logic [4:0]  m_rega, m_regb, m_dreg;
    logic [3:0]  m_op;
    bit          kill, live;

    always @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            m_valid = 0; m_we = 0; m_mr = 1; m_mw = 0; m_bs = 0;
            m_pc = 0; m_a = 0; m_b = 0; m_imm = 0;
            m_rega = 0; m_regb = 0; m_dreg = 0; m_op = 0;
        end else if (hold) begin
            m_bs = 0;
        end else begin
            kill = flush || (bubble && !_stall_en);
            live = !kill && id_valid;
            m_pc = id_pc; m_a = id_a; m_b = id_b; m_imm = id_imm;
            m_rega = id_rega; m_regb = id_regb;
            m_valid = live;
            m_we    = live ? id_we      : 1'b0;
            m_mr    = live ? id_mem_reg : 1'b1;
            m_mw    = live ? id_mem_we  : 1'b0;
            m_dreg  = live ? id_dreg    : 5'd0;
            m_op    = live ? id_aluop   : 4'd0;
            m_bs    = bubble && !flush && kill;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid",   {31'd0, exe_valid},   {31'd0, m_valid});
            chk("pc",      exe_pc,               m_pc);
            chk("a",       exe_a,                m_a);
            chk("b",       exe_b,                m_b);
            chk("imm",     exe_imm,              m_imm);
            chk("rega",    {27'd0, exe_rega},    {27'd0, m_rega});
            chk("regb",    {27'd0, exe_regb},    {27'd0, m_regb});
            chk("dreg",    {27'd0, exe_wb_dreg}, {27'd0, m_dreg});
            chk("we",      {31'd0, exe_wb_we},   {31'd0, m_we});
            chk("mem_reg", {31'd0, exe_mem_reg}, {31'd0, m_mr});
            chk("mem_we",  {31'd0, exe_mem_we},  {31'd0, m_mw});
            chk("aluop",   {28'd0, exe_aluop},   {28'd0, m_op});
            chk("bseen",   {31'd0, bubble_seen}, {31'd0, m_bs});
        end
    end

    // Apply one cycle of inputs, return 2 time units after the edge.
    task automatic drive(input logic h, input logic f, input logic bb,
                         input logic se, input logic v,
                         input logic [31:0] pc, input logic [4:0] d,
                         input logic we, input logic mr, input logic mw,
                         input logic [3:0] op);
        hold = h; flush = f; bubble = bb; _stall_en = se;
        id_valid = v; id_pc = pc; id_dreg = d;
        id_we = we; id_mem_reg = mr; id_mem_we = mw; id_aluop = op;
        id_a = pc ^ 32'hA5A5_0000; id_b = ~pc; id_imm = pc + 32'd4;
        id_rega = d + 5'd1; id_regb = d + 5'd2;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [31:0] r;
        // Reset with noisy ID inputs.
        drive(0, 0, 0, 1, 1, 32'hDEAD_BEEF, 5'd17, 1, 0, 1, 4'd3);
        cmp_en = 1'b1;
        drive(0, 0, 0, 1, 1, 32'h1234_5678, 5'd22, 1, 0, 1, 4'd5);
        chk("rst_valid", {31'd0, exe_valid},   32'd0);
        chk("rst_we",    {31'd0, exe_wb_we},   32'd0);
        chk("rst_mr",    {31'd0, exe_mem_reg}, 32'd1);
        chk("rst_dreg",  {27'd0, exe_wb_dreg}, 32'd0);
        _rst = 1'b1;
        drive(0, 0, 0, 1, 1, 32'h40, 5'd5, 1, 1, 0, 4'd0);
        chk("t1_pc",   exe_pc, 32'h40);
        chk("t1_dreg", {27'd0, exe_wb_dreg}, 32'd5);

        // Load-use: load into EXE, then bubble, then re-issue.
        drive(0, 0, 0, 1, 1, 32'h44, 5'd8, 1, 0, 0, 4'd0);
        chk("t2_load_mr", {31'd0, exe_mem_reg}, 32'd0);
        drive(0, 0, 1, 0, 1, 32'h48, 5'd3, 1, 1, 0, 4'd1);
        chk("t2_nop_valid", {31'd0, exe_valid},   32'd0);
        chk("t2_nop_mr",    {31'd0, exe_mem_reg}, 32'd1);
        chk("t2_bseen",     {31'd0, bubble_seen}, 32'd1);
        drive(0, 0, 0, 1, 1, 32'h48, 5'd3, 1, 1, 0, 4'd1);
        chk("t2_reissue_pc", exe_pc, 32'h48);
        chk("t2_reissue_v",  {31'd0, exe_valid},   32'd1);
        chk("t2_bseen_clr",  {31'd0, bubble_seen}, 32'd0);

        // Flush and bubble together.
        drive(0, 1, 1, 0, 1, 32'h4C, 5'd4, 1, 1, 1, 4'd2);
        chk("t3_valid", {31'd0, exe_valid},   32'd0);
        chk("t3_bseen", {31'd0, bubble_seen}, 32'd0);

        // Hold over bubble with dreg 9 in EXE.
        drive(0, 0, 0, 1, 1, 32'h50, 5'd9, 1, 0, 0, 4'd6);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 0, 1, 32'h60 + i, 5'd12, 1, 1, 1, 4'd7);
            chk("t4_hold_dreg", {27'd0, exe_wb_dreg}, 32'd9);
            chk("t4_hold_pc",   exe_pc, 32'h50);
        end
        drive(0, 0, 1, 0, 1, 32'h70, 5'd12, 1, 1, 0, 4'd7);
        chk("t4_nop_valid", {31'd0, exe_valid},   32'd0);
        chk("t4_nop_dreg",  {27'd0, exe_wb_dreg}, 32'd0);

        // Invalid ID slot.
        drive(0, 0, 0, 1, 0, 32'h74, 5'd6, 1, 1, 1, 4'd4);
        chk("t5_we",    {31'd0, exe_wb_we},  32'd0);
        chk("t5_mw",    {31'd0, exe_mem_we}, 32'd0);
        chk("t5_valid", {31'd0, exe_valid},  32'd0);

        // Mixed legal traffic, model-checked.
        for (int i = 0; i < 60; i++) begin
            r = $urandom;
            drive(r[3:0] == 4'd0, r[7:5] == 3'd0, r[8], r[8] ? 1'b0 : r[9],
                  r[10] | r[11], $urandom, r[16:12], r[17], r[18], r[19],
                  r[23:20]);
        end

        // Reset in the middle of a stall.
        drive(0, 0, 0, 1, 1, 32'h80, 5'd8, 1, 0, 0, 4'd0);
        hold = 0; flush = 0; bubble = 1; _stall_en = 0;
        _rst = 1'b0;
        #1;
        chk("t7_rst_valid", {31'd0, exe_valid},   32'd0);
        chk("t7_rst_mr",    {31'd0, exe_mem_reg}, 32'd1);
        drive(0, 0, 0, 1, 1, 32'h84, 5'd2, 1, 1, 0, 4'd0);
        _rst = 1'b1;
        drive(0, 0, 0, 1, 1, 32'h88, 5'd2, 1, 1, 0, 4'd0);
        chk("t7_after_pc", exe_pc, 32'h88);

`ifdef ID_EXE_PERF_EN
        perf_clr = 1'b1;
        drive(0, 0, 0, 1, 1, 32'h90, 5'd1, 1, 1, 0, 4'd0);
        perf_clr = 1'b0;
        chk("p_clr0", perf_bubbles, 32'd0);
        for (int i = 0; i < 4; i++)
            drive(0, 0, 1, 0, 1, 32'h94, 5'd1, 1, 1, 0, 4'd0);
        for (int i = 0; i < 2; i++)
            drive(0, 1, 0, 1, 1, 32'h98, 5'd1, 1, 1, 0, 4'd0);
        for (int i = 0; i < 3; i++)
            drive(1, 0, 1, 0, 1, 32'h9C, 5'd1, 1, 1, 0, 4'd0);
        chk("p_bub",  perf_bubbles, 32'd4);
        chk("p_fl",   perf_flushes, 32'd2);
        chk("p_hold", perf_holds,   32'd3);
        perf_clr = 1'b1;
        drive(0, 0, 1, 0, 1, 32'hA0, 5'd1, 1, 1, 0, 4'd0);
        perf_clr = 1'b0;
        chk("p_clr_b", perf_bubbles, 32'd0);
        chk("p_clr_f", perf_flushes, 32'd0);
        chk("p_clr_h", perf_holds,   32'd0);
        force dut.u_cnt_bub.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_cnt_bub.cnt_q;
        drive(0, 0, 1, 0, 1, 32'hA4, 5'd1, 1, 1, 0, 4'd0);
        chk("p_sat", perf_bubbles, 32'hFFFF_FFFF);
`endif

        drive(0, 0, 0, 1, 1, 32'hB0, 5'd3, 1, 1, 0, 4'd0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
